// File: rtl/serial_tx_pkg.sv
// Shared definitions for the single-wire serial link (transmit and receive ends).
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } serial_state_e;

  // Line levels: the line rests high and a frame opens with a low start bit.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Parity mode selector values.
  localparam int PARITY_MODE_EVEN = 0;
  localparam int PARITY_MODE_ODD  = 1;

  // Width of a counter spanning 0..range-1, never narrower than one bit.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_baud_tick_gen.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per line bit and flags the last one.
module baud_tick_gen
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);

  localparam int             CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Free-run 0..CLKS_PER_BIT-1 while enabled, held at 0 while cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_done = ~clr & (r_cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit, data LSB first, optional parity, stop bit.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy
);

  localparam int            BW       = cnt_width(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic          ODD_SEL  = (PARITY_ODD == PARITY_MODE_ODD);

  serial_state_e     r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_parity;
  logic              r_txd;
  logic              r_busy;

  logic              w_clr;
  logic              w_bit_done;
  logic [DATA_W-1:0] w_shift_next;

  // The bit timer only runs while a frame is on the line.
  assign w_clr        = (r_state == ST_IDLE);
  assign w_shift_next = r_shift >> 1;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .bit_done(w_bit_done)
  );

  // Frame sequencer; txd is loaded with the level of the state being entered so it
  // changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_txd     <= LINE_IDLE;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd <= LINE_IDLE;
          if (tx_valid) begin
            r_shift   <= tx_data;
            r_parity  <= (^tx_data) ^ ODD_SEL;
            r_bit_cnt <= '0;
            r_state   <= ST_START;
            r_txd     <= LINE_START;
            r_busy    <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            r_txd     <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            if (r_bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                r_state <= ST_PARITY;
                r_txd   <= r_parity;
              end else begin
                r_state <= ST_STOP;
                r_txd   <= LINE_IDLE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= w_shift_next;
              r_txd     <= w_shift_next[0];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_state <= ST_STOP;
            r_txd   <= LINE_IDLE;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_state <= ST_IDLE;
            r_txd   <= LINE_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_txd   <= LINE_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = (r_state == ST_IDLE);
  assign txd      = r_txd;
  assign busy     = r_busy;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: four instances cover plain, even/odd parity and 1-clock bits.
module tb_serial_tx;

  typedef struct packed {
    logic [15:0] f;      // frame bits, first-out bit at the MSB end of f[nb-1:0]
    logic [7:0]  nb;     // number of line bits in the frame
    logic [7:0]  gap;    // required idle samples before this frame
    logic        gap_en;
    logic        abort;  // frame is expected to be cut short by reset
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a      [4];
  logic [7:0] tx_data_a  [4];
  logic       tx_valid_a [4];
  logic       ready_a    [4];
  logic       txd_a      [4];
  logic       busy_a     [4];

  exp_t exp_q [4][$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_plain (
    .clk(clk), .rst(rst_a[0]), .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]),
    .tx_ready(ready_a[0]), .txd(txd_a[0]), .busy(busy_a[0]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst_a[1]), .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]),
    .tx_ready(ready_a[1]), .txd(txd_a[1]), .busy(busy_a[1]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst_a[2]), .tx_data(tx_data_a[2]), .tx_valid(tx_valid_a[2]),
    .tx_ready(ready_a[2]), .txd(txd_a[2]), .busy(busy_a[2]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
    .clk(clk), .rst(rst_a[3]), .tx_data(tx_data_a[3]), .tx_valid(tx_valid_a[3]),
    .tx_ready(ready_a[3]), .txd(txd_a[3]), .busy(busy_a[3]));

  function automatic int cpb_of(input int k);
    return (k == 3) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, k, act, req);
    end
  endtask

  // Offer one word at a negedge; push its expected frame once acceptance is certain.
  task automatic send(input int k, input logic [7:0] d, input logic [15:0] f, input int nb,
                      input int gap, input bit gap_en, input bit hold, input bit abort);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    tx_data_a[k]  = d;
    tx_valid_a[k] = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (ready_a[k]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", k, 64'd0, 64'd1);
      tx_valid_a[k] = 1'b0;
      return;
    end
    e.f = f; e.nb = 8'(nb); e.gap = 8'(gap); e.gap_en = gap_en; e.abort = abort;
    exp_q[k].push_back(e);
    @(negedge clk);
    if (!hold) tx_valid_a[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (exp_q[k].size() == 0 && !busy_a[k]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", k, 64'd0, 64'd1);
  endtask

  // Per-instance monitor: captures txd while busy and scores each completed frame.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    initial begin
      exp_t        cur;
      bit          cap;
      bit          rbad;
      int          len;
      int          idle;
      int          gap;
      int          cpb;
      logic [63:0] vec;
      logic [63:0] ev;
      cap = 1'b0; rbad = 1'b0; len = 0; idle = 1000; gap = 0; cur = '0; vec = '0;
      cpb = cpb_of(g);
      forever begin
        @(posedge clk);
        #1;
        if (rst_a[g]) begin
          if (cap) chk("abort_expected", g, 64'(cur.abort), 64'd1);
          cap  = 1'b0;
          idle = 1000;
        end else begin
          if (busy_a[g] && !cap) begin
            if (exp_q[g].size() == 0) begin
              chk("unexpected_frame", g, 64'd1, 64'd0);
              cur = '0;
            end else begin
              cur = exp_q[g].pop_front();
            end
            cap = 1'b1; len = 0; vec = '0; rbad = 1'b0; gap = idle;
          end
          if (cap && busy_a[g]) begin
            if (len < 64) vec[len] = txd_a[g];
            len++;
            if (ready_a[g]) rbad = 1'b1;
          end else if (cap) begin
            ev = '0;
            for (int i = 0; i < int'(cur.nb); i++)
              for (int c = 0; c < cpb; c++)
                ev[i*cpb + c] = cur.f[int'(cur.nb) - 1 - i];
            chk("abort_missing", g, 64'(cur.abort), 64'd0);
            chk("frame_len", g, 64'(len), 64'(int'(cur.nb) * cpb));
            chk("frame_bits", g, vec, ev);
            chk("ready_low", g, 64'(rbad), 64'd0);
            if (cur.gap_en) chk("gap", g, 64'(gap), 64'(cur.gap));
            cap  = 1'b0;
            idle = 0;
          end
          if (!busy_a[g]) idle++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst_a[k] = 1'b1; tx_data_a[k] = 8'h00; tx_valid_a[k] = 1'b0;
    end
    // Reset held 3 cycles with a word already offered.
    tx_data_a[0]  = 8'hA5;
    tx_valid_a[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_txd",   0, 64'(txd_a[0]),   64'd1);
      chk("rst_busy",  0, 64'(busy_a[0]),  64'd0);
      chk("rst_ready", 0, 64'(ready_a[0]), 64'd1);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) rst_a[k] = 1'b0;

    // 8'hA5, no parity: 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5, 16'(10'b0101001011), 10, 0, 1'b0, 1'b0, 1'b0);
    wait_idle(0);

    // Back-to-back 8'h01 then 8'hFF with tx_data disturbed mid-frame.
    send(0, 8'h01, 16'(10'b0100000001), 10, 0, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    tx_data_a[0] = 8'hFF;
    send(0, 8'hFF, 16'(10'b0111111111), 10, 1, 1'b1, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    tx_data_a[0]  = 8'h00;
    tx_valid_a[0] = 1'b0;
    wait_idle(0);

    // 8'hC3 abandoned by reset in data bit 3, then a clean 8'h3C.
    send(0, 8'hC3, 16'd0, 10, 0, 1'b0, 1'b0, 1'b1);
    repeat (17) @(negedge clk);
    rst_a[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_txd",   0, 64'(txd_a[0]),   64'd1);
    chk("midrst_ready", 0, 64'(ready_a[0]), 64'd1);
    chk("midrst_busy",  0, 64'(busy_a[0]),  64'd0);
    @(negedge clk);
    rst_a[0] = 1'b0;
    send(0, 8'h3C, 16'(10'b0001111001), 10, 0, 1'b0, 1'b0, 1'b0);
    wait_idle(0);

    // Parity: 8'h07 even -> 1, odd -> 0; 8'hA5 odd -> 1.
    send(1, 8'h07, 16'(11'b01110000011), 11, 0, 1'b0, 1'b0, 1'b0);
    wait_idle(1);
    send(2, 8'h07, 16'(11'b01110000001), 11, 0, 1'b0, 1'b0, 1'b0);
    wait_idle(2);
    send(2, 8'hA5, 16'(11'b01010010111), 11, 0, 1'b0, 1'b0, 1'b0);
    wait_idle(2);

    // One clock per bit.
    send(3, 8'h80, 16'(10'b0000000011), 10, 0, 1'b0, 1'b0, 1'b0);
    wait_idle(3);
    send(3, 8'h3C, 16'(10'b0001111001), 10, 0, 1'b0, 1'b0, 1'b0);
    wait_idle(3);

    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) chk("queue_empty", k, 64'(exp_q[k].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
